// File: rtl/reg_file_mp_if.sv
// Port bundle for reg_file_mp: write port, NRD read ports, scoreboard set and soft-clear handshake.
interface reg_file_mp_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic                    we;
  logic [ADDR_W-1:0]       wa;
  logic [WIDTH-1:0]        wd;
  logic [NRD*ADDR_W-1:0]   ra;
  logic [NRD*WIDTH-1:0]    rd;
  logic [NRD-1:0]          rpend;
  logic                    sb_set;
  logic [ADDR_W-1:0]       sb_addr;
  logic                    clr_req;
  logic                    clr_busy;
  logic                    clr_done;

  modport master (
    output we, wa, wd, ra, sb_set, sb_addr, clr_req,
    input  rd, rpend, clr_busy, clr_done
  );

  modport slave (
    input  we, wa, wd, ra, sb_set, sb_addr, clr_req,
    output rd, rpend, clr_busy, clr_done
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with x0 hardwired to zero, pending-write scoreboard and soft-clear sweep.
// Define REGFILE_BYPASS_EN to forward the same-cycle write to matching read ports.

module reg_file_mp_rport #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int ENTRIES = 32
) (
  input  logic [ENTRIES-1:0][WIDTH-1:0] mem,
  input  logic [ENTRIES-1:0]            pending,
  input  logic [ADDR_W-1:0]             ra,
  input  logic                          fwd_en,
  input  logic [ADDR_W-1:0]             wa,
  input  logic [WIDTH-1:0]              wd,
  input  logic                          set_ok,
  input  logic [ADDR_W-1:0]             sb_addr,
  output logic [WIDTH-1:0]              rd,
  output logic                          rpend
);
  logic nz, hit;

  assign nz  = (ra != '0);
  assign hit = fwd_en && (wa == ra);

  // A forwarded write retires its producer unless a newer one issues this same cycle.
  always_comb begin
    rd    = '0;
    rpend = 1'b0;
    if (nz) begin
      rd    = hit ? wd : mem[ra];
      rpend = hit ? (set_ok && (sb_addr == ra)) : pending[ra];
    end
  end
endmodule

module reg_file_mp #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int ENTRIES = 32,
  parameter int NRD     = 2
) (
  input  logic         clk,
  input  logic         areset,
  reg_file_mp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                        state, state_nxt;
  logic [ADDR_W-1:0]             idx;
  logic [ENTRIES-1:0][WIDTH-1:0] mem;
  logic [ENTRIES-1:0]            pending;
  logic                          idle, wr_ok, set_ok, fwd_en;
  logic [NRD-1:0][ADDR_W-1:0]    ra_lane;
  logic [NRD-1:0][WIDTH-1:0]     rd_lane;

  assign idle   = (state == IDLE);
  assign wr_ok  = idle && bus.we     && (bus.wa != '0);
  assign set_ok = idle && bus.sb_set && (bus.sb_addr != '0);

`ifdef REGFILE_BYPASS_EN
  assign fwd_en = wr_ok;
`else
  assign fwd_en = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clr_req) state_nxt = SWEEP;
      SWEEP:   if (idx == ADDR_W'(ENTRIES-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state   <= IDLE;
      idx     <= '0;
      mem     <= '0;
      pending <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (wr_ok) begin
            mem[bus.wa]     <= bus.wd;
            pending[bus.wa] <= 1'b0;
          end
          // Set after write so a same-address collision leaves the bit pending.
          if (set_ok) pending[bus.sb_addr] <= 1'b1;
          if (bus.clr_req) begin
            idx     <= ADDR_W'(1);
            pending <= '0;
          end
        end
        SWEEP: begin
          mem[idx] <= '0;
          idx      <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ra_lane      = bus.ra;
  assign bus.rd       = rd_lane;
  assign bus.clr_busy = !idle;
  assign bus.clr_done = (state == DONE);

  for (genvar i = 0; i < NRD; i++) begin : g_rport
    reg_file_mp_rport #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ENTRIES(ENTRIES)) u_rport (
      .mem     (mem),
      .pending (pending),
      .ra      (ra_lane[i]),
      .fwd_en  (fwd_en),
      .wa      (bus.wa),
      .wd      (bus.wd),
      .set_ok  (set_ok),
      .sb_addr (bus.sb_addr),
      .rd      (rd_lane[i]),
      .rpend   (bus.rpend[i])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: reset, x0, scoreboard, same-cycle read, soft clear, reset mid-sweep.
module tb_reg_file_mp;
  localparam int WIDTH = 32, ADDR_W = 5, ENTRIES = 32, NRD = 2;

  logic clk = 1'b0;
  logic areset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  reg_file_mp_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NRD(NRD)) bus ();

  reg_file_mp #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .NRD(NRD)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input logic [ADDR_W-1:0] a);
    bus.ra[p*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [WIDTH-1:0] rdp(input int p);
    return bus.rd[p*WIDTH +: WIDTH];
  endfunction

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    bus.we = 1'b1; bus.wa = a; bus.wd = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic test_reset();
    bus.we = 0; bus.wa = 0; bus.wd = 0; bus.ra = '0;
    bus.sb_set = 0; bus.sb_addr = 0; bus.clr_req = 0;
    areset = 1'b0;
    #12;
    set_ra(0, 5); set_ra(1, 31);
    #1;
    checks++; if (bus.rd !== '0) begin errors++; $display("FAIL reset_rd got=%h exp=0", bus.rd); end
    checks++; if (bus.rpend !== '0) begin errors++; $display("FAIL reset_rpend got=%b exp=0", bus.rpend); end
    checks++; if ({bus.clr_busy, bus.clr_done} !== 2'b00) begin errors++; $display("FAIL reset_clr got=%b exp=00", {bus.clr_busy, bus.clr_done}); end
    @(negedge clk); areset = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    wr(5, 32'hDEADBEEF);
    set_ra(0, 5); set_ra(1, 0);
    #1;
    checks++; if (rdp(0) !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_x5 got=%h exp=deadbeef", rdp(0)); end
    checks++; if (rdp(1) !== 32'h0) begin errors++; $display("FAIL rd_x0 got=%h exp=0", rdp(1)); end
  endtask

  task automatic test_zero();
    wr(0, 32'h12345678);
    set_ra(0, 0);
    bus.sb_set = 1; bus.sb_addr = 0;
    tick();
    bus.sb_set = 0;
    checks++; if (rdp(0) !== 32'h0) begin errors++; $display("FAIL x0_write got=%h exp=0", rdp(0)); end
    checks++; if (bus.rpend[0] !== 1'b0) begin errors++; $display("FAIL x0_pend got=%b exp=0", bus.rpend[0]); end
  endtask

  task automatic test_scoreboard();
    bus.sb_set = 1; bus.sb_addr = 7;
    tick();
    bus.sb_set = 0;
    tick(); tick();
    set_ra(0, 7); set_ra(1, 8);
    #1;
    checks++; if (bus.rpend !== 2'b01) begin errors++; $display("FAIL sb_x7_pend got=%b exp=01", bus.rpend); end
    wr(7, 32'h55);
    checks++; if (bus.rpend[0] !== 1'b0) begin errors++; $display("FAIL sb_x7_clear got=%b exp=0", bus.rpend[0]); end
    checks++; if (rdp(0) !== 32'h55) begin errors++; $display("FAIL sb_x7_data got=%h exp=55", rdp(0)); end
    bus.sb_set = 1; bus.sb_addr = 9;
    bus.we = 1; bus.wa = 9; bus.wd = 32'h99;
    tick();
    bus.sb_set = 0; bus.we = 0;
    set_ra(1, 9);
    #1;
    checks++; if (bus.rpend[1] !== 1'b1) begin errors++; $display("FAIL sb_collide_pend got=%b exp=1", bus.rpend[1]); end
    checks++; if (rdp(1) !== 32'h99) begin errors++; $display("FAIL sb_collide_data got=%h exp=99", rdp(1)); end
  endtask

  task automatic test_same_cycle();
    logic [WIDTH-1:0] exp;
    wr(3, 32'h11);
    bus.we = 1; bus.wa = 3; bus.wd = 32'hA5A5A5A5;
    set_ra(0, 3);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hA5A5A5A5;
`else
    exp = 32'h11;
`endif
    checks++; if (rdp(0) !== exp) begin errors++; $display("FAIL same_cycle got=%h exp=%h", rdp(0), exp); end
    tick();
    bus.we = 0;
    checks++; if (rdp(0) !== 32'hA5A5A5A5) begin errors++; $display("FAIL after_write got=%h exp=a5a5a5a5", rdp(0)); end
  endtask

  task automatic test_sweep();
    int cnt, dones;
    for (int i = 1; i < ENTRIES; i++) wr(ADDR_W'(i), 32'h1000_0000 | i);
    bus.sb_set = 1; bus.sb_addr = 12;
    tick();
    bus.sb_set = 0;
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    cnt = 0; dones = 0;
    while (bus.clr_busy && cnt < 100) begin
      cnt++;
      if (bus.clr_done) dones++;
      if (cnt == 5) begin bus.we = 1; bus.wa = 4; bus.wd = 32'hBAD; end
      if (cnt == 6) bus.we = 0;
      tick();
    end
    bus.we = 0;
    checks++; if (cnt !== 32) begin errors++; $display("FAIL sweep_busy_cycles got=%0d exp=32", cnt); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL sweep_done_pulses got=%0d exp=1", dones); end
    checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL sweep_done_after got=%b exp=0", bus.clr_done); end
    for (int i = 0; i < ENTRIES; i += 2) begin
      set_ra(0, ADDR_W'(i)); set_ra(1, ADDR_W'(i + 1));
      #1;
      checks++; if (bus.rd !== '0) begin errors++; $display("FAIL sweep_clear x%0d got=%h exp=0", i, bus.rd); end
      checks++; if (bus.rpend !== '0) begin errors++; $display("FAIL sweep_pend x%0d got=%b exp=0", i, bus.rpend); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 8; i < 21; i++) wr(ADDR_W'(i), 32'hC000_0000 | i);
    bus.clr_req = 1;
    tick();
    bus.clr_req = 0;
    repeat (9) tick();
    areset = 1'b0;
    #1;
    checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", bus.clr_busy); end
    checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", bus.clr_done); end
    @(negedge clk); areset = 1'b1;
    repeat (3) begin
      tick();
      checks++; if ({bus.clr_busy, bus.clr_done} !== 2'b00) begin errors++; $display("FAIL rst_mid_after got=%b exp=00", {bus.clr_busy, bus.clr_done}); end
    end
    for (int i = 8; i < 21; i++) begin
      set_ra(0, ADDR_W'(i));
      #1;
      checks++; if (rdp(0) !== 32'h0) begin errors++; $display("FAIL rst_mid_clear x%0d got=%h exp=0", i, rdp(0)); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero();
    test_scoreboard();
    test_same_cycle();
    test_sweep();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
